serial_word_tx: RTL and testbench

Parallel-to-serial front end for `shift_register`.
- Accepts WIDTH-bit words over a valid/ready handshake into a one-deep holding register.
- Serializes each word MSB- or LSB-first at a programmable bit rate, driving the downstream `d_i`/`en_i`/`dir_i` inputs directly.
- Back-to-back words stream with no idle cycle between them.

---
 rtl/serial_word_tx.sv | 102 ++++++++++
 tb/tb_serial_word_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter with a one-deep holding register.
// Drives a downstream shift_register's d/en/dir inputs at a programmable bit rate.
module serial_word_tx #(
  parameter int WIDTH = 32,
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             lsb_first_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_o,
  output logic             bit_en_o,
  output logic             dir_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_lsb_q;
  logic [DIV_W-1:0] hold_div_q;
  logic             hold_vld_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic [DIV_W-1:0] dcnt_q;
  logic [DIV_W-1:0] div_q;
  logic             lsb_q;

  logic busy;
  logic strobe;
  logic last;
  logic accept;
  logic xfer;

  assign busy   = (state_q == SHIFT);
  assign strobe = busy && (dcnt_q == '0);
  assign last   = strobe && (cnt_q == CW'(WIDTH - 1));
  assign accept = valid_i && ready_o;
  // Hold feeds the shifter when idle, or on the last strobe for gapless streaming.
  assign xfer   = hold_vld_q && (!busy || last);

  assign ready_o  = rstn_i && !hold_vld_q;
  assign busy_o   = busy;
  assign bit_en_o = strobe;
  assign done_o   = last;
  assign dir_o    = busy && lsb_q;
  assign bit_o    = busy && (lsb_q ? sh_q[0] : sh_q[WIDTH-1]);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_lsb_q <= 1'b0;
      hold_div_q <= '0;
      hold_vld_q <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      div_q      <= '0;
      lsb_q      <= 1'b0;
    end else begin
      if (accept) begin
        hold_q     <= data_i;
        hold_lsb_q <= lsb_first_i;
        hold_div_q <= div_i;
        hold_vld_q <= 1'b1;
      end else if (xfer) begin
        hold_vld_q <= 1'b0;
      end

      if (xfer) begin
        state_q <= SHIFT;
        sh_q    <= hold_q;
        lsb_q   <= hold_lsb_q;
        div_q   <= hold_div_q;
        dcnt_q  <= hold_div_q;
        cnt_q   <= '0;
      end else if (strobe) begin
        sh_q   <= lsb_q ? {1'b0, sh_q[WIDTH-1:1]}
                        : {sh_q[WIDTH-2:0], 1'b0};
        cnt_q  <= cnt_q + 1'b1;
        dcnt_q <= div_q;
        if (last) begin
          state_q <= IDLE;
        end
      end else if (busy) begin
        dcnt_q <= dcnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: directed scenarios plus random words,
// checked against a per-strobe event model built from word/order/divider.
module tb_serial_word_tx;

  localparam int W  = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [W-1:0]  data = '0;
  logic          valid = 1'b0;
  logic          lsb = 1'b0;
  logic [DW-1:0] div = '0;
  logic          ready_o, bit_o, bit_en_o, dir_o, busy_o, done_o;

  serial_word_tx #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .data_i     (data),
    .valid_i    (valid),
    .ready_o    (ready_o),
    .lsb_first_i(lsb),
    .div_i      (div),
    .bit_o      (bit_o),
    .bit_en_o   (bit_en_o),
    .dir_o      (dir_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic b;
    logic d;
    logic dn;
  } ev_t;

  ev_t obs[$];
  ev_t expq[$];
  int  stray = 0;
  int  busy_cnt = 0;
  int  done_cnt = 0;

  always @(negedge clk) begin
    if (bit_en_o) obs.push_back('{cyc, bit_o, dir_o, done_o});
    if (done_o && !bit_en_o) stray++;
    if (busy_o) busy_cnt++;
    if (done_o) done_cnt++;
  end

  int checks = 0;
  int passed = 0;
  int prev_e = -100;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) passed++;
    else $error("FAIL %s got=%0d want=%0d", tag, got, want);
  endtask

  // Offer a word; while not ready, data/order/div wander to prove only
  // the value present at the accepting edge is captured.
  task automatic send(input logic [W-1:0] w, input logic l,
                      input logic [DW-1:0] dv);
    int n;
    int a;
    int ld;
    n = 0;
    forever begin
      @(negedge clk);
      valid = 1'b1;
      if (ready_o) begin
        data = w;
        lsb  = l;
        div  = dv;
        break;
      end
      data = W'($urandom);
      lsb  = 1'($urandom);
      div  = DW'($urandom);
      n++;
      if (n > 5000) begin
        chk("send_timeout", 0, 1);
        valid = 1'b0;
        return;
      end
    end
    a = cyc + 1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = W'($urandom);
    ld = (a + 1 > prev_e + 1) ? a + 1 : prev_e + 1;
    for (int k = 0; k < W; k++) begin
      ev_t e;
      e.c  = ld + int'(dv) + k * (int'(dv) + 1);
      e.b  = l ? w[k] : w[W-1-k];
      e.d  = l;
      e.dn = (k == W - 1);
      expq.push_back(e);
    end
    prev_e = ld + W * (int'(dv) + 1) - 1;
  endtask

  task automatic settle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_o || !ready_o) && n < 5000);
    if (n >= 5000) chk("settle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    int m;
    chk({tag, "_count"}, obs.size(), expq.size());
    m = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_cyc"},  obs[i].c,       expq[i].c);
      chk({tag, "_bit"},  int'(obs[i].b), int'(expq[i].b));
      chk({tag, "_dir"},  int'(obs[i].d), int'(expq[i].d));
      chk({tag, "_done"}, int'(obs[i].dn), int'(expq[i].dn));
    end
    chk({tag, "_stray_done"}, stray, 0);
    obs.delete();
    expq.delete();
  endtask

  initial begin
    logic [W-1:0] rec;
    int d0;
    int n;

    // reset and idle
    repeat (3) @(negedge clk);
    chk("rst_ready_low", int'(ready_o), 0);
    rstn = 1'b1;
    #1;
    chk("rst_vals", int'({ready_o, bit_o, bit_en_o, dir_o, busy_o, done_o}),
        int'(6'b100000));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_vals",
          int'({ready_o, bit_o, bit_en_o, dir_o, busy_o, done_o}),
          int'(6'b100000));
    end

    // MSB first, div 0
    send(8'hA5, 1'b0, 4'd0);
    settle();
    rec = '0;
    foreach (obs[i]) rec = {rec[W-2:0], obs[i].b};
    chk("a5_downstream", int'(rec), 'hA5);
    compare("a5");

    // LSB first, div 2
    busy_cnt = 0;
    send(8'h3C, 1'b1, 4'd2);
    settle();
    chk("3c_busy", busy_cnt, 24);
    compare("3c");

    // back-to-back streaming
    d0 = done_cnt;
    send(8'h0F, 1'b0, 4'd0);
    send(8'hF0, 1'b0, 4'd0);
    chk("b2b_ready", int'(ready_o), 0);
    settle();
    chk("b2b_dones", done_cnt - d0, 2);
    compare("b2b");

    // largest divider
    send(8'h96, 1'b1, 4'd15);
    settle();
    compare("maxdiv");

    // reset during bit 4 with a word held
    send(8'hFF, 1'b0, 4'd0);
    send(8'h55, 1'b0, 4'd0);
    n = 0;
    while (obs.size() < 4 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_mid_reach", obs.size(), 4);
    d0 = done_cnt;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy_o), 0);
    chk("rst_mid_ready", int'(ready_o), 1);
    while (expq.size() > obs.size()) void'(expq.pop_back());
    prev_e = -100;
    compare("rst_mid");
    repeat (30) @(negedge clk);
    chk("rst_mid_quiet", obs.size(), 0);
    chk("rst_mid_nodone", done_cnt - d0, 0);

    // random words with random gaps
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      send(W'($urandom), 1'($urandom), DW'($urandom_range(0, 3)));
    end
    settle();
    compare("rand");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
